// File: rtl/jtdsp16_sout_fifo.sv
// jtdsp16_sout_fifo
//   Serial output port with a word FIFO. The CPU pushes words, which are
//   shifted out on sdo under a generated ock. Every piece of state moves only
//   on the cen clock enable. The ock/old/ose/doen pins behave like the
//   single-buffer DSP16 SIO, so this block can stand in for it.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   cen          clock enable; all state updates are gated by it
//   wr, din      write strobe and the word to enqueue
//   lsb_first    shift order, latched when a word is loaded (0 = MSB first)
//   doen         output enable; 0 freezes shifting while ock keeps running
//   ovf_clr      clears the sticky overflow flag
//   sdo, ock     serial data and serial clock
//   old          one-cycle pulse in the cycle a word moves into the shifter
//   ose          shifter empty (FSM idle)
//   obe, full    FIFO empty / FIFO full
//   level        number of words waiting in the FIFO
//   ovf          sticky flag: a write was dropped because the FIFO was full
module jtdsp16_sout_fifo #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          lsb_first,
  input  logic          doen,
  input  logic          ovf_clr,
  output logic          sdo,
  output logic          ock,
  output logic          old,
  output logic          ose,
  output logic          obe,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(DW);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic          lsbf_q, lsbf_d;
  logic          sdo_q, sdo_d;
  logic          ock_q;
  logic          ovf_q, ovf_d;
  logic          bit_tick, pop, push, drop;
  logic [DW-1:0] head;

  // A bit tick is the cen cycle in which ock is high; ock falls on it, so
  // sdo only changes on the falling edge of ock.
  assign bit_tick = cen & ock_q;
  assign head     = mem_q[rptr_q];
  assign obe      = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));

  // Shifter FSM. Pops are qualified by the registered obe, so a word pushed
  // into an empty FIFO cannot be popped in its own push cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    lsbf_d   = lsbf_q;
    sdo_d    = sdo_q;
    pop      = 1'b0;
    if (bit_tick && doen) begin
      if (state_q == SHIFT && bitcnt_q != '0) begin
        shift_d  = lsbf_q ? (shift_q >> 1) : (shift_q << 1);
        sdo_d    = lsbf_q ? shift_q[1] : shift_q[DW-2];
        bitcnt_d = bitcnt_q - 1'b1;
      end else if (!obe) begin
        // Load from IDLE, or back-to-back reload after the last bit.
        pop      = 1'b1;
        shift_d  = head;
        lsbf_d   = lsb_first;
        bitcnt_d = CW'(DW-1);
        sdo_d    = lsb_first ? head[0] : head[DW-1];
        state_d  = SHIFT;
      end else if (state_q == SHIFT) begin
        state_d = IDLE;
        sdo_d   = 1'b0;
      end
    end
  end

  // FIFO bookkeeping: a full FIFO still accepts a write when it pops in the
  // same cycle; otherwise the write is dropped and flagged. A drop wins over
  // a simultaneous clear.
  always_comb begin
    push    = cen & wr & (~full | pop);
    drop    = cen & wr & full & ~pop;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (cen && ovf_clr)
      ovf_d = 1'b0;
  end

  // Control and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      lsbf_q   <= 1'b0;
      sdo_q    <= 1'b0;
      ock_q    <= 1'b0;
      ovf_q    <= 1'b0;
      level_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else if (cen) begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      lsbf_q   <= lsbf_d;
      sdo_q    <= sdo_d;
      ock_q    <= ~ock_q;
      ovf_q    <= ovf_d;
      level_q  <= level_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO storage needs no reset: the cleared pointers make it empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign sdo   = sdo_q;
  assign ock   = ock_q;
  assign old   = pop;
  assign ose   = (state_q == IDLE);
  assign level = level_q;
  assign ovf   = ovf_q;

endmodule
